// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
// Received-byte stream between the UART receiver and its consumer.
// Latency: none, wires only.
// Backpressure: consumer drives rx_ready; a byte transfers when rx_valid & rx_ready.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_overrun;

  // Receiver side: produces bytes and flags, observes ready.
  modport master (
    output rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun,
    input  rx_ready
  );

  // Consumer side: observes bytes and flags, drives ready.
  modport slave (
    input  rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// UART receiver, 16x oversampled with mid-bit sampling; optional parity via UART_RX_PARITY_EN.
// Latency: byte valid 1 clk after the stop-bit mid-sample (plus 2 clk input synchroniser).
// Backpressure: one-byte holding register; a frame completing while it is full is dropped and rx_overrun pulses.
module uart_rx #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rx_busy,
  uart_rx_if.master rx_if
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic [15:0] PRESC_MAX = 16'(CLK_DIV - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

  // Input synchroniser; rxd is asynchronous to clk.
  logic rxd_m_q, rxd_s_q;

  // Receive FSM state.
  logic [2:0]           state_q, state_d;
  logic [15:0]          presc_q, presc_d;
  logic [3:0]           samp_q,  samp_d;
  logic [2:0]           bit_q,   bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 armed_q, armed_d;
  logic                 done_q,  done_d;
  logic                 ferr_q,  ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q,   par_d;
  logic                 pe_calc;
  logic                 pe_q,    pe_d;
`endif

  // Output holding register.
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q,    fe_d;
  logic                 ovr_q,   ovr_d;

  logic tick;
  logic mid;
  logic xfer;

  assign tick = (presc_q == PRESC_MAX);
  // 16th tick of a bit measured from the previous mid-bit point.
  assign mid  = tick && (samp_q == 4'd15);
  assign xfer = valid_q && rx_if.rx_ready;

`ifdef UART_RX_PARITY_EN
  assign pe_calc = ((^shreg_q) ^ par_q) != (PARITY_ODD != 0);
`endif

  // Two-flop synchroniser, idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      rxd_m_q <= rxd;
      rxd_s_q <= rxd_m_q;
    end
  end

  // Next-state logic for prescaler, sample/bit counters and frame FSM.
  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    // A start edge is only taken after at least one clock of idle-high,
    // so a held-low line (break) yields a single frame.
    armed_d = (state_q == S_IDLE) && rxd_s_q;
    // Prescaler rests at 0 in IDLE, which aligns its phase to the start edge.
    if (state_q == S_IDLE) begin
      presc_d = 16'd0;
    end else if (tick) begin
      presc_d = 16'd0;
    end else begin
      presc_d = presc_q + 16'd1;
    end
    if (tick) begin
      samp_d = samp_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        samp_d = 4'd0;
        if (armed_q && !rxd_s_q) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick && samp_q == 4'd7) begin
          if (rxd_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            samp_d  = 4'd0;
            bit_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (mid) begin
          shreg_d = {rxd_s_q, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (mid) begin
          par_d   = rxd_s_q;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // Return to IDLE at mid stop bit so back-to-back frames are caught.
        if (mid) begin
          ferr_d  = ~rxd_s_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register: load completed frame, handle handshake and overrun.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_d    = pe_q;
`endif
    if (done_q) begin
      if (!valid_q || xfer) begin
        data_d  = shreg_q;
        fe_d    = ferr_q;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        pe_d    = pe_calc;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= 16'd0;
      samp_q  <= 4'd0;
      bit_q   <= 3'd0;
      shreg_q <= '0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pe_q    <= 1'b0;
`endif
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      armed_q <= armed_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pe_q    <= pe_d;
`endif
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_busy             = (state_q != S_IDLE);
  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_valid      = valid_q;
  assign rx_if.rx_frame_err  = fe_q;
  assign rx_if.rx_overrun    = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.rx_parity_err = pe_q;
`else
  assign rx_if.rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Bench for uart_rx: serial frames driven bit by bit, bytes checked against a frame-level model.
module tb_uart_rx;
  localparam int CLK_DIV    = 4;
  localparam int DATA_BITS  = 8;
  localparam int PARITY_ODD = 0;
  localparam int BIT        = 16 * CLK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = DATA_BITS + 3;
`else
  localparam int NBITS = DATA_BITS + 2;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic rx_busy;

  uart_rx_if #(.DATA_BITS(DATA_BITS)) rx_if ();

  uart_rx #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS), .PARITY_ODD(PARITY_ODD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rxd    (rxd),
    .rx_busy(rx_busy),
    .rx_if  (rx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor: cycle count, accepted bytes, overrun pulses, valid-high cycles.
  int unsigned cyc = 0;
  rec_t obs_q[$];
  int   ovr_cnt = 0;
  int   valid_cycles = 0;
  int unsigned rise_cyc = 0;
  logic valid_prev = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (rx_if.rx_valid && rx_if.rx_ready)
        obs_q.push_back({rx_if.rx_data, rx_if.rx_frame_err, rx_if.rx_parity_err});
      if (rx_if.rx_overrun) ovr_cnt <= ovr_cnt + 1;
      if (rx_if.rx_valid) valid_cycles <= valid_cycles + 1;
      if (rx_if.rx_valid && !valid_prev) rise_cyc <= cyc;
      valid_prev <= rx_if.rx_valid;
    end else begin
      valid_prev <= 1'b0;
    end
  end

  // Expected result of one frame, from the bits put on the line.
  function automatic rec_t model(input logic [7:0] d, input logic par, input logic stop);
    rec_t r;
    int ones = 0;
    for (int i = 0; i < DATA_BITS; i++) ones += int'(d[i]);
    r.data = d;
    r.fe   = (stop == 1'b0);
`ifdef UART_RX_PARITY_EN
    r.pe   = (((ones + int'(par)) % 2) != PARITY_ODD);
`else
    r.pe   = 1'b0 & par & (ones >= 0);
`endif
    return r;
  endfunction

  // Parity bit value that makes a frame correct.
  function automatic logic par_ok(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < DATA_BITS; i++) ones += int'(d[i]);
    return ((ones + PARITY_ODD) % 2) == 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int budget, input string tag);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(obs_q.size() >= n), 32'd1);
  endtask

  task automatic cmp_rec(input string tag, input rec_t e);
    rec_t o;
    o = 'x;
    if (obs_q.size() != 0) o = obs_q.pop_front();
    chk({tag, ".data"}, 32'(o.data), 32'(e.data));
    chk({tag, ".ferr"}, 32'(o.fe), 32'(e.fe));
    chk({tag, ".perr"}, 32'(o.pe), 32'(e.pe));
  endtask

  initial begin
    #(3_000_000);
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned t0;
    int base_ovr, base_vc, k;
    logic [7:0] d;
    logic p, s;
    rec_t exp_q[$];

    rx_if.rx_ready = 1'b1;
    rxd   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_if.rx_valid), 32'd0);
    chk("rst_data",  32'(rx_if.rx_data), 32'd0);
    chk("rst_ferr",  32'(rx_if.rx_frame_err), 32'd0);
    chk("rst_perr",  32'(rx_if.rx_parity_err), 32'd0);
    chk("rst_ovr",   32'(rx_if.rx_overrun), 32'd0);
    chk("rst_busy",  32'(rx_busy), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic receive, plus latency from the start of the stop bit.
    base_vc = valid_cycles;
    t0 = cyc;
    send_frame(8'hA5, par_ok(8'hA5), 1'b1);
    wait_obs(1, 200, "basic_wait");
    cmp_rec("basic", model(8'hA5, par_ok(8'hA5), 1'b1));
    k = int'(rise_cyc - t0) - (NBITS - 1) * BIT;
    chk("basic_latency_window", 32'(k >= BIT / 2 && k <= BIT / 2 + 8), 32'd1);
    repeat (4) @(negedge clk);
    chk("basic_valid_one_clk", 32'(valid_cycles - base_vc), 32'd1);

    // Glitch rejection.
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_busy_hi", 32'(rx_busy), 32'd1);
    rxd = 1'b1;
    k = 0;
    while (rx_busy && k < 20) begin @(negedge clk); k++; end
    chk("glitch_busy_lo", 32'(rx_busy), 32'd0);
    repeat (100) @(negedge clk);
    chk("glitch_no_byte", 32'(obs_q.size()), 32'd0);

    // Framing error, then a clean frame.
    send_frame(8'h3C, par_ok(8'h3C), 1'b0);
    drive_bit(1'b1);
    send_frame(8'h55, par_ok(8'h55), 1'b1);
    wait_obs(2, 300, "ferr_wait");
    cmp_rec("ferr_3c", model(8'h3C, par_ok(8'h3C), 1'b0));
    cmp_rec("ferr_55", model(8'h55, par_ok(8'h55), 1'b1));

    // Overrun with backpressure.
    rx_if.rx_ready = 1'b0;
    base_ovr = ovr_cnt;
    send_frame(8'h11, par_ok(8'h11), 1'b1);
    send_frame(8'h22, par_ok(8'h22), 1'b1);
    repeat (20) @(negedge clk);
    chk("ovr_pulses", 32'(ovr_cnt - base_ovr), 32'd1);
    chk("ovr_valid_held", 32'(rx_if.rx_valid), 32'd1);
    chk("ovr_data_held", 32'(rx_if.rx_data), 32'h11);
    rx_if.rx_ready = 1'b1;
    wait_obs(1, 10, "ovr_drain_wait");
    cmp_rec("ovr_drain", model(8'h11, par_ok(8'h11), 1'b1));
    @(negedge clk);
    chk("ovr_valid_drop", 32'(rx_if.rx_valid), 32'd0);

    // Parity good and bad (flag stays 0 when parity is compiled out).
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1);
    wait_obs(2, 300, "par_wait");
    cmp_rec("par_good", model(8'h07, 1'b1, 1'b1));
    cmp_rec("par_bad",  model(8'h07, 1'b0, 1'b1));

    // Break: line held low gives exactly one zero byte with frame error.
    rxd = 1'b0;
    repeat (20 * BIT) @(negedge clk);
    chk("break_one_byte", 32'(obs_q.size()), 32'd1);
    cmp_rec("break", model(8'h00, 1'b0, 1'b0));
    drive_bit(1'b1);
    send_frame(8'h5A, par_ok(8'h5A), 1'b1);
    wait_obs(1, 200, "post_break_wait");
    cmp_rec("post_break", model(8'h5A, par_ok(8'h5A), 1'b1));

    // Randomised frames with random gaps; a bad stop bit needs an idle gap.
    exp_q.delete();
    for (int n = 0; n < 10; n++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 3) != 0);
      exp_q.push_back(model(d, p, s));
      send_frame(d, p, s);
      k = s ? int'($urandom_range(0, 16)) : BIT + int'($urandom_range(0, 16));
      repeat (k) @(negedge clk);
    end
    wait_obs(10, 300, "rand_wait");
    for (int n = 0; n < 10; n++) cmp_rec($sformatf("rand%0d", n), exp_q[n]);

    // Reset mid-frame drops a held byte and the partial frame.
    rx_if.rx_ready = 1'b0;
    send_frame(8'h77, par_ok(8'h77), 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    rxd = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_valid", 32'(rx_if.rx_valid), 32'd0);
    chk("mid_rst_data", 32'(rx_if.rx_data), 32'd0);
    chk("mid_rst_busy", 32'(rx_busy), 32'd0);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    rx_if.rx_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_no_byte", 32'(obs_q.size()), 32'd0);
    send_frame(8'h0F, par_ok(8'h0F), 1'b1);
    wait_obs(1, 200, "post_rst_wait");
    cmp_rec("post_rst", model(8'h0F, par_ok(8'h0F), 1'b1));
    repeat (50) @(negedge clk);
    chk("post_rst_only_one", 32'(obs_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
